// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite slave terminating one transaction at a time into a word-addressed RAM,
// with programmable read/write wait states. Optional SLVERR responses: AXI_MEM_ERR_RESP_EN.
module axi4lite_slave_mem #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  output logic        bvalid,
`ifdef AXI_MEM_ERR_RESP_EN
  input  logic        bready,
  output logic [1:0]  rresp,
  output logic [1:0]  bresp
`else
  input  logic        bready
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, AR_ACK, RD_WAIT, RD_RESP, AW_ACK, WR_WAIT, WR_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     lat_cnt_q, lat_cnt_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           oor_q, oor_d;
  logic [1:0]     resp_q, resp_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           rd_load, wr_commit, mem_we;
  logic           ar_oor, aw_oor;
  logic           unused_addr_bits;

  logic [31:0]    mem [DEPTH];

`ifdef AXI_MEM_ERR_RESP_EN
  assign ar_oor = (araddr[31:AW+2] != '0);
  assign aw_oor = (awaddr[31:AW+2] != '0);
`else
  // Upper address bits are ignored, so addresses alias modulo DEPTH*4.
  assign ar_oor = 1'b0;
  assign aw_oor = 1'b0;
`endif
  assign unused_addr_bits = ^{araddr[31:AW+2], araddr[1:0], awaddr[31:AW+2], awaddr[1:0]};

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    idx_d     = idx_q;
    oor_d     = oor_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    rd_load   = 1'b0;
    wr_commit = 1'b0;
    case (state_q)
      IDLE: begin
        // A complete write request takes priority over a simultaneous read.
        if (awvalid && wvalid) begin
          idx_d   = awaddr[AW+1:2];
          oor_d   = aw_oor;
          wdata_d = wdata;
          state_d = AW_ACK;
        end else if (arvalid) begin
          idx_d   = araddr[AW+1:2];
          oor_d   = ar_oor;
          state_d = AR_ACK;
        end
      end
      AR_ACK: begin
        lat_cnt_d = 4'(RD_LAT);
        if (RD_LAT == 0) begin
          state_d = RD_RESP;
          rd_load = 1'b1;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          state_d = RD_RESP;
          rd_load = 1'b1;
        end
      end
      RD_RESP: if (rready) state_d = IDLE;
      AW_ACK: begin
        lat_cnt_d = 4'(WR_LAT);
        if (WR_LAT == 0) begin
          state_d   = WR_RESP;
          wr_commit = 1'b1;
        end else begin
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) begin
          state_d   = WR_RESP;
          wr_commit = 1'b1;
        end
      end
      WR_RESP: if (bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rd_load) rdata_d = oor_q ? 32'h0 : mem[idx_q];
    if (rd_load || wr_commit) resp_d = oor_q ? 2'b10 : 2'b00;
    mem_we = wr_commit && !oor_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= 4'd0;
      rdata_q   <= 32'h0;
      oor_q     <= 1'b0;
      resp_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      rdata_q   <= rdata_d;
      oor_q     <= oor_d;
      resp_q    <= resp_d;
    end
  end

  // Request payload and RAM carry no reset; an aborted write never reaches mem_we.
  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign arready = (state_q == AR_ACK);
  assign awready = (state_q == AW_ACK);
  assign wready  = (state_q == AW_ACK);
  assign rvalid  = (state_q == RD_RESP);
  assign bvalid  = (state_q == WR_RESP);
  assign rdata   = rdata_q;

`ifdef AXI_MEM_ERR_RESP_EN
  assign rresp = rvalid ? resp_q : 2'b00;
  assign bresp = bvalid ? resp_q : 2'b00;
`endif

endmodule

// File: doc/axi4lite_slave_mem.md
# axi4lite_slave_mem

AXI4-Lite slave with an internal word-addressed RAM. It sits directly downstream of the cache-side AXI4-Lite controller and terminates its read and write channels. Programmable wait states model memory latency. Exactly one transaction is outstanding at a time, matching the controller's single-request behaviour.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two; `AW = $clog2(DEPTH)`.
- `RD_LAT`, 2: extra wait cycles between the `arready` pulse and `rvalid`; range 0..15.
- `WR_LAT`, 2: extra wait cycles between the `awready`/`wready` pulse and `bvalid`; range 0..15.

Ports:
- `clk` in 1: the block's one clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `arvalid` in 1: read address valid.
- `arready` out 1: read address accepted; one-cycle pulse.
- `araddr` in 32: byte address of the read.
- `rvalid` out 1: read data valid.
- `rready` in 1: master accepts read data.
- `rdata` out 32: read data.
- `awvalid` in 1: write address valid.
- `awready` out 1: write address accepted; one-cycle pulse.
- `awaddr` in 32: byte address of the write.
- `wvalid` in 1: write data valid.
- `wready` out 1: write data accepted; pulses together with `awready`.
- `wdata` in 32: write data.
- `bvalid` out 1: write response valid.
- `bready` in 1: master accepts the write response.
- `rresp`, `bresp` out 2: response codes; present only with `AXI_MEM_ERR_RESP_EN`.

## Operation
- States: IDLE, AR_ACK, RD_WAIT, RD_RESP, AW_ACK, WR_WAIT, WR_RESP. A 4-bit down-counter `lat_cnt` times the wait states.
- **Read path**
  - IDLE with `arvalid`=1 (and no write pending): latch `araddr`, go to AR_ACK.
  - AR_ACK: drive `arready`=1 for this cycle. Load `lat_cnt` with `RD_LAT`. Go to RD_WAIT, or straight to RD_RESP if `RD_LAT`=0.
  - RD_WAIT: decrement `lat_cnt` each cycle. When it reaches 1, go to RD_RESP.
  - RD_RESP: on entry, register `rdata` = mem[word index]. Hold `rvalid`=1 and `rdata` stable until `rready`=1, then return to IDLE.
- **Write path**
  - IDLE with `awvalid`=1 and `wvalid`=1: latch `awaddr` and `wdata`, go to AW_ACK.
  - If only one of `awvalid`/`wvalid` is high, stay in IDLE.
  - AW_ACK: drive `awready`=1 and `wready`=1 together for this cycle. Load `WR_LAT`. Go to WR_WAIT, or to WR_RESP if `WR_LAT`=0.
  - On entry to WR_RESP: write mem[word index] = latched `wdata`. Hold `bvalid`=1 until `bready`=1, then return to IDLE.
- **Arbitration:** in IDLE, a write (both `awvalid` and `wvalid` high) wins over a simultaneous `arvalid`. The read is taken after the write returns to IDLE.
- **Word index:** `addr[AW+1:2]`; `addr[1:0]` is ignored.
- **Ready signals:** they are Moore outputs and never depend combinationally on valid inputs. `arready`/`awready` are never high in the same cycle as `rvalid`/`bvalid`.
- **Reset:**
  - All outputs go to 0 and the FSM goes to IDLE. `rdata` resets to 0; `lat_cnt` resets to 0.
  - RAM contents are not reset.
  - Reset mid-transaction aborts the transaction. A write in AW_ACK or WR_WAIT is not committed.
- **Retained values:** `rdata` keeps its value after the handshake until the next RD_RESP entry.

## Timing
- **Read latency:** `arvalid` sampled at cycle T, `arready` at T+1, `rvalid` at T+2+`RD_LAT`.
- **Write latency:** `awvalid`&`wvalid` sampled at T, `awready`/`wready` at T+1, `bvalid` and RAM update at T+2+`WR_LAT`.
- **Back-to-back:** the minimum gap is one IDLE cycle between transactions.
- **Interoperation with the controller:** it raises valid in its own IDLE, sees `arready` without `rvalid`, and moves to its data-wait state. The one-cycle-delayed ready pulse is required for this.

## Configuration
- `AXI_MEM_ERR_RESP_EN` defined:
  - `rresp`/`bresp` ports exist.
  - Addresses with `addr[31:AW+2]`≠0 are out of range and return SLVERR (2'b10).
  - An out-of-range read returns `rdata`=0; an out-of-range write is dropped.
  - In-range accesses return OKAY (2'b00).
  - Both resp outputs are valid only while their valid signal is high and reset to 0.
- Not defined: no resp ports; upper address bits are ignored, so addresses alias modulo DEPTH×4.

## Test plan
- **Write then read:** write 0xDEADBEEF to 0x10, then read 0x10. Expect `bvalid` at T+4 and `rdata`=0xDEADBEEF with `rvalid` at T+4 (`RD_LAT`=2).
- **Zero latency:** with `RD_LAT`=`WR_LAT`=0, `arready` at T+1 and `rvalid` at T+2 with no RD_WAIT cycle. The same holds for `bvalid` on writes.
- **Backpressure:** hold `rready`=0 for 5 cycles with `rvalid` up. `rvalid` and `rdata` stay stable; one cycle after `rready`=1, the FSM is in IDLE.
- **Simultaneous requests:** `arvalid`, `awvalid` and `wvalid` all high at the same edge. The write is serviced first; the read of the same address returns the new data.
- **Partial write request:** `awvalid`=1 with `wvalid`=0 for 3 cycles. No `awready` is issued; once `wvalid` rises, `awready`/`wready` pulse one cycle later.
- **Reset during WR_WAIT:** all outputs go to 0 and the FSM to IDLE. A later read of that address returns the old value.
- **With `AXI_MEM_ERR_RESP_EN`:** read 0x0001_0000 with `DEPTH`=1024. Expect `rresp`=2'b10 and `rdata`=0.
